// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, clocks out 8 serial bits, commits them to buttons.
// Optional macro NES_PAD_DEBOUNCE_EN: commit only when two consecutive frames agree.
module nes_pad_reader #(
    parameter int HALF_PERIOD = 150
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       poll,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic       valid,
    output logic       busy
);
    // state    | meaning
    // IDLE     | waiting for poll
    // LATCH    | nes_latch high for two half periods
    // SETTLE   | latch released, bit 0 sampled on last cycle
    // PULSE_HI | nes_clk high, pad shifts next bit
    // PULSE_LO | nes_clk low, bit pair_cnt sampled on last cycle
    // COMMIT   | shifted frame moved to buttons
    typedef enum logic [2:0] {IDLE, LATCH, SETTLE, PULSE_HI, PULSE_LO, COMMIT} state_t;

    localparam logic [9:0] RELOAD = 10'(HALF_PERIOD - 1);

    state_t     state, state_next;
    logic [9:0] cnt;
    logic [2:0] pair_cnt;
    logic [7:0] shift_reg;
    logic [1:0] sync_q;
    logic       tc;
    logic       commit_ok;
    logic       latch_d, clk_d;

    assign tc   = (cnt == 10'd0);
    assign busy = (state != IDLE);

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
        end else begin
            state     <= state_next;
            nes_latch <= latch_d;
            nes_clk   <= clk_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (poll) state_next = LATCH;
            LATCH:    if (tc && pair_cnt == 3'd1) state_next = SETTLE;
            SETTLE:   if (tc) state_next = PULSE_HI;
            PULSE_HI: if (tc) state_next = PULSE_LO;
            PULSE_LO: if (tc) state_next = (pair_cnt == 3'd7) ? COMMIT : PULSE_HI;
            COMMIT:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes decoded from the next state so the registered pins track the state exactly.
    always_comb begin
        latch_d = (state_next == LATCH);
        clk_d   = (state_next == PULSE_HI);
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], nes_data};
    end

`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0] raw_frame;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset)               raw_frame <= 8'h00;
        else if (state == COMMIT) raw_frame <= shift_reg;
    end

    assign commit_ok = (shift_reg == raw_frame);
`else
    assign commit_ok = 1'b1;
`endif

    // LATCH spans two half periods, using pair_cnt 0 -> 1 to fit the 10-bit timer.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            cnt       <= 10'd0;
            pair_cnt  <= 3'd0;
            shift_reg <= 8'h00;
            buttons   <= 8'h00;
            pressed   <= 8'h00;
            valid     <= 1'b0;
        end else begin
            pressed <= 8'h00;
            valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll) begin
                        cnt      <= RELOAD;
                        pair_cnt <= 3'd0;
                    end
                end
                LATCH: begin
                    if (tc) begin
                        cnt      <= RELOAD;
                        pair_cnt <= 3'd1;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                end
                SETTLE: begin
                    if (tc) begin
                        cnt          <= RELOAD;
                        shift_reg[0] <= ~sync_q[1];
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                end
                PULSE_HI: begin
                    if (tc) cnt <= RELOAD;
                    else    cnt <= cnt - 10'd1;
                end
                PULSE_LO: begin
                    if (tc) begin
                        shift_reg[pair_cnt] <= ~sync_q[1];
                        pair_cnt            <= pair_cnt + 3'd1;
                        cnt                 <= (pair_cnt == 3'd7) ? 10'd0 : RELOAD;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                end
                COMMIT: begin
                    cnt      <= 10'd0;
                    pair_cnt <= 3'd0;
                    if (commit_ok) begin
                        buttons <= shift_reg;
                        pressed <= shift_reg & ~buttons;
                        valid   <= 1'b1;
                    end
                end
                default: cnt <= 10'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: table of frames plus reset/back-to-back/long-period sequences.
module tb_nes_pad_reader;
    logic       clk25 = 1'b0;
    logic       reset;
    logic       poll, poll2;
    logic       nes_data, nes_data2;
    logic       nes_latch, nes_clk, valid, busy;
    logic [7:0] buttons, pressed;
    logic       nes_latch2, nes_clk2, valid2, busy2;
    logic [7:0] buttons2, pressed2;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap_cnt = 0;
    int leak_cnt    = 0;

    always #5 clk25 = ~clk25;

    nes_pad_reader #(.HALF_PERIOD(4)) dut (
        .clk25(clk25), .reset(reset), .poll(poll), .nes_data(nes_data),
        .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
        .pressed(pressed), .valid(valid), .busy(busy)
    );

    nes_pad_reader #(.HALF_PERIOD(150)) dut_slow (
        .clk25(clk25), .reset(reset), .poll(poll2), .nes_data(nes_data2),
        .nes_latch(nes_latch2), .nes_clk(nes_clk2), .buttons(buttons2),
        .pressed(pressed2), .valid(valid2), .busy(busy2)
    );

    // Pad model: parallel load on latch, shift on rising nes_clk, active-low serial output.
    logic [7:0] pad_frame = 8'h00;
    logic [7:0] pad_sr    = 8'h00;
    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) pad_sr = pad_frame;
        else           pad_sr = {1'b0, pad_sr[7:1]};
    end
    assign nes_data  = ~pad_sr[0];
    assign nes_data2 = 1'b1;

    always @(negedge clk25) begin
        if (nes_latch && nes_clk)   overlap_cnt++;
        if (nes_latch2 && nes_clk2) overlap_cnt++;
        if (!valid && pressed != 8'h00) leak_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_read(input logic [7:0] f, output int lat, output int lw,
                           output int pulses, output logic [7:0] b, output logic [7:0] p);
        logic prev_clk;
        pad_frame = f;
        lat = -1; lw = 0; pulses = 0; b = buttons; p = 8'h00;
        @(negedge clk25); poll = 1'b1;
        @(posedge clk25); #1; poll = 1'b0;
        prev_clk = 1'b0;
        for (int n = 0; n < 90; n++) begin
            if (n > 0) begin @(posedge clk25); #1; end
            if (nes_latch) lw++;
            if (nes_clk && !prev_clk) pulses++;
            prev_clk = nes_clk;
            b = buttons;
            if (valid) begin
                lat = n;
                p = pressed;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] frame;
        logic       exp_valid;
        logic [7:0] exp_buttons;
        logic [7:0] exp_pressed;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        int         lat, lw, pulses, rises, vcount, gap;
        logic [7:0] b, p;
        logic       prev;

`ifdef NES_PAD_DEBOUNCE_EN
        vecs.push_back('{8'h01, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h02, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h02, 1'b1, 8'h02, 8'h02});
`else
        vecs.push_back('{8'h09, 1'b1, 8'h09, 8'h09});
        vecs.push_back('{8'h09, 1'b1, 8'h09, 8'h00});
        vecs.push_back('{8'h18, 1'b1, 8'h18, 8'h10});
        vecs.push_back('{8'hFF, 1'b1, 8'hFF, 8'hE7});
        vecs.push_back('{8'h00, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{8'h81, 1'b1, 8'h81, 8'h81});
`endif

        reset = 1'b0; poll = 1'b0; poll2 = 1'b0;
        repeat (3) @(negedge clk25);
        check("rst_buttons", int'(buttons), 0);
        check("rst_pressed", int'(pressed), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_latch", int'(nes_latch), 0);
        check("rst_clk", int'(nes_clk), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk25);

        // Abort a read during the 4th PULSE_HI.
        pad_frame = 8'h09;
        @(negedge clk25); poll = 1'b1;
        @(posedge clk25); #1; poll = 1'b0;
        rises = 0; prev = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk25); #1;
            if (nes_clk && !prev) rises++;
            prev = nes_clk;
            if (rises == 4) break;
        end
        check("rst_mid_reach_pulse4", rises, 4);
        @(posedge clk25); #2; reset = 1'b0;
        #1;
        check("rst_mid_clk", int'(nes_clk), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_buttons", int'(buttons), 0);
        @(negedge clk25); reset = 1'b1;
        vcount = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk25); #1;
            if (valid) vcount++;
        end
        check("rst_mid_no_valid", vcount, 0);
        check("rst_mid_buttons_after", int'(buttons), 0);

        foreach (vecs[i]) begin
            do_read(vecs[i].frame, lat, lw, pulses, b, p);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_latency", i), lat, 69);
                check($sformatf("v%0d_latch_width", i), lw, 8);
                check($sformatf("v%0d_pulses", i), pulses, 7);
                check($sformatf("v%0d_buttons", i), int'(b), int'(vecs[i].exp_buttons));
                check($sformatf("v%0d_pressed", i), int'(p), int'(vecs[i].exp_pressed));
            end else begin
                check($sformatf("v%0d_no_valid", i), lat, -1);
                check($sformatf("v%0d_buttons_hold", i), int'(b), int'(vecs[i].exp_buttons));
            end
        end

`ifndef NES_PAD_DEBOUNCE_EN
        // poll held high: one IDLE cycle (the valid cycle) between reads.
        pad_frame = 8'h81;
        @(negedge clk25); poll = 1'b1;
        vcount = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk25); #1;
            if (valid) begin vcount = 1; break; end
        end
        check("b2b_first_valid", vcount, 1);
        check("b2b_busy_at_valid", int'(busy), 0);
        @(posedge clk25); #1;
        check("b2b_relatch", int'(nes_latch), 1);
        gap = 1;
        while (!valid && gap < 100) begin
            @(posedge clk25); #1;
            gap++;
        end
        poll = 1'b0;
        check("b2b_gap", gap, 70);
        repeat (3) @(posedge clk25); #1;
        check("b2b_stops", int'(busy), 0);

        // poll pulse injected mid-read is ignored.
        @(negedge clk25); poll = 1'b1;
        @(posedge clk25); #1; poll = 1'b0;
        repeat (30) @(posedge clk25); #1; poll = 1'b1;
        @(posedge clk25); #1; poll = 1'b0;
        vcount = 0;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk25); #1;
            if (valid) vcount++;
        end
        check("midpoll_single_read", vcount, 1);
        check("midpoll_idle", int'(busy), 0);
`endif

        // Default half period: 300-cycle latch, 150-cycle clock high, valid after 2551.
        @(negedge clk25); poll2 = 1'b1;
        @(posedge clk25); #1; poll2 = 1'b0;
        lat = -1; lw = 0; rises = 0; gap = 0; prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) begin @(posedge clk25); #1; end
            if (nes_latch2) lw++;
            if (nes_clk2 && !prev) rises++;
            prev = nes_clk2;
            if (nes_clk2 && rises == 1) gap++;
            if (valid2) begin lat = n; break; end
        end
        check("slow_latch_width", lw, 300);
        check("slow_clk_high", gap, 150);
        check("slow_pulses", rises, 7);
        check("slow_latency", lat, 2551);

        check("latch_clk_overlap", overlap_cnt, 0);
        check("pressed_outside_valid", leak_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 150, giving nes_clk half-period in clk25 cycles (6 us at 25 MHz); legal range 4..1023.
REQ-002 The block SHALL have port clk25  input  1  pixel clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port poll  input  1  start-of-read request, normally driven by the display's screenEnd.
REQ-005 The block SHALL have port nes_data  input  1  serial data from the controller, active-low (0 = pressed), asynchronous.
REQ-006 The block SHALL have port nes_latch  output  1  controller latch strobe, active-high.
REQ-007 The block SHALL have port nes_clk  output  1  controller shift clock, idle low.
REQ-008 The block SHALL have port buttons  output  8  debounced button state, active-high: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-009 The block SHALL have port pressed  output  8  one-cycle pulse per bit that changed from 0 to 1 at the last commit.
REQ-010 The block SHALL have port valid  output  1  one-cycle strobe marking a buttons commit.
REQ-011 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 nes_data SHALL pass through a two-flop synchronizer before use.
REQ-013 The FSM states SHALL be IDLE, LATCH, SETTLE, PULSE_HI, PULSE_LO, COMMIT.
REQ-014 IDLE -> LATCH on any edge where poll=1; poll while busy=1 SHALL be ignored, with no queuing.
REQ-015 LATCH SHALL last 2*HALF_PERIOD cycles with nes_latch=1; SETTLE SHALL last HALF_PERIOD cycles with nes_latch=0 and nes_clk=0.
REQ-016 The inverted synchronized nes_data SHALL be sampled into shift bit0 on the last SETTLE cycle.
REQ-017 There SHALL be exactly 7 pulse pairs: PULSE_HI (nes_clk=1, HALF_PERIOD cycles) then PULSE_LO (nes_clk=0, HALF_PERIOD cycles), with bit i (i=1..7) sampled on the last cycle of the i-th PULSE_LO.
REQ-018 After the 7th PULSE_LO the FSM SHALL enter COMMIT for one cycle and then return to IDLE.
REQ-019 valid SHALL be high exactly 17*HALF_PERIOD+1 cycles after the edge that accepts poll, for one cycle, together with the new buttons and pressed values.
REQ-020 pressed SHALL equal new_buttons AND NOT old_buttons during the valid cycle, and SHALL be 0 in every other cycle.
REQ-021 A single 10-bit down-counter SHALL time every phase, and a 3-bit counter SHALL count pulse pairs; no phase SHALL be shortened or lengthened by poll.
REQ-022 nes_latch and nes_clk SHALL be registered outputs and SHALL never be high simultaneously.

Reset
REQ-023 While reset=0 the outputs SHALL be: buttons=0, pressed=0, valid=0, busy=0, nes_latch=0, nes_clk=0; the FSM SHALL be in IDLE, and the counters, shift register, and debounce register SHALL be 0.
REQ-024 Reset asserted mid-read SHALL abort the read immediately with no commit; the first poll after release SHALL start a full read.

Configuration
REQ-025 With macro NES_PAD_DEBOUNCE_EN defined, COMMIT SHALL update buttons and pulse valid only if the shifted frame equals the previous raw frame; otherwise buttons SHALL hold, valid and pressed SHALL stay 0, and the raw frame SHALL be stored.
REQ-026 Without NES_PAD_DEBOUNCE_EN, every COMMIT SHALL update buttons and pulse valid, and no raw-frame register SHALL exist.

Verification (HALF_PERIOD=4 unless stated)
REQ-027 Reset release, then a one-cycle poll with the model returning A+Start (serial 0,1,1,0,1,1,1,1) -> nes_latch high for 8 cycles, 7 nes_clk pulses, valid 69 cycles after accept, buttons=8'h09, pressed=8'h09.
REQ-028 Two consecutive reads of the same frame 8'h09 -> the second valid shows buttons=8'h09 and pressed=8'h00; a third read of 8'h18 -> pressed=8'h10.
REQ-029 poll held high continuously -> reads run back-to-back, with exactly one IDLE cycle between COMMIT and the next LATCH; a poll pulse injected mid-read -> no extra read occurs.
REQ-030 reset pulsed low during the 4th PULSE_HI -> nes_clk=0 within the reset cycle, no valid occurs, buttons keep their reset value 0, and the next poll yields a correct full read.
REQ-031 With NES_PAD_DEBOUNCE_EN defined, frames 8'h01, 8'h02, 8'h02 -> no valid on the first two reads; valid with buttons=8'h02 on the third.
REQ-032 HALF_PERIOD=150 -> nes_latch width 300 cycles (12 us), nes_clk high 150 cycles (6 us), valid 2551 cycles after accept.
